// File: rtl/decoding_block.sv
// Receive-side 64b/66b / 128b/132b symbol decoder.
// Checks the sync header of each lane, drops illegal or lane-inconsistent
// symbols, buffers up to two accepted symbols and replays their payload
// one byte per lane per clock.
module decoding_block #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 dec_clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [1:0]           gen_speed,
    input  logic [131:0]         lane_0_rx_enc,
    input  logic [131:0]         lane_1_rx_enc,
    input  logic                 sym_valid,
    output logic                 sym_ready,
    output logic [7:0]           lane_0_rx,
    output logic [7:0]           lane_1_rx,
    output logic                 rx_valid,
    output logic                 rx_sos,
    output logic                 rx_os,
    output logic                 sync_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [1:0] GEN_RAW = 2'd0;
    localparam logic [1:0] GEN_4   = 2'd1;
    localparam logic [1:0] GEN_3   = 2'd2;
    localparam logic [1:0] GEN_RSV = 2'd3;

    typedef enum logic {IDLE, UNLOAD} state_t;

    state_t                 state_reg, state_next;
    logic                   en_reg;
    logic [1:0]             gen_reg;
    logic [1:0]             count_reg, count_next;
    logic                   wr_ptr_reg, wr_ptr_next;
    logic                   rd_ptr_reg, rd_ptr_next;
    logic [3:0]             idx_reg, idx_next;
    logic                   rx_valid_reg, rx_sos_reg, rx_os_reg;
    logic                   rej_pend_reg, sync_err_reg;
    logic [ERR_CNT_W-1:0]   err_cnt_reg;

    logic                   flush, emit, last, pop, accept, reject, wr_en;
    logic [3:0]             n_last;

    logic [131:0]           lane_enc [2];
    logic                   mem_type [2];

    assign lane_enc[0] = lane_0_rx_enc;
    assign lane_enc[1] = lane_1_rx_enc;

    // Per-lane header decode, payload extraction, payload storage and output byte.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic         is_data;
            logic         is_os;
            logic [127:0] pay;
            logic [127:0] mem [2];
            logic [7:0]   byte_reg;

            // Classify the header and strip it according to the active mode.
            always_comb begin
                is_data = 1'b0;
                is_os   = 1'b0;
                pay     = '0;
                case (gen_reg)
                    GEN_3: begin
                        is_data = (lane_enc[gi][1:0] == 2'b01);
                        is_os   = (lane_enc[gi][1:0] == 2'b10);
                        pay     = {64'd0, lane_enc[gi][65:2]};
                    end
                    GEN_4: begin
                        is_data = (lane_enc[gi][3:0] == 4'b0101);
                        is_os   = (lane_enc[gi][3:0] == 4'b1010);
                        pay     = lane_enc[gi][131:4];
                    end
                    GEN_RAW: begin
                        is_data = 1'b1;
                        pay     = {120'd0, lane_enc[gi][7:0]};
                    end
                    default: ;
                endcase
            end

            // Payload storage; occupancy tracking makes a reset unnecessary here.
            always_ff @(posedge dec_clk) begin
                if (wr_en) begin
                    mem[wr_ptr_reg] <= pay;
                end
            end

            // Registered byte output, forced to zero whenever nothing is emitted.
            always_ff @(posedge dec_clk or negedge rst) begin
                if (!rst) begin
                    byte_reg <= 8'd0;
                end else if (emit) begin
                    byte_reg <= mem[rd_ptr_reg][{idx_reg, 3'b000} +: 8];
                end else begin
                    byte_reg <= 8'd0;
                end
            end
        end
    endgenerate

    // Symbol type is shared by both lanes once accepted, so lane 0 provides it.
    always_ff @(posedge dec_clk) begin
        if (wr_en) begin
            mem_type[wr_ptr_reg] <= g_lane[0].is_os;
        end
    end

    assign sym_ready = en_reg && (count_reg < 2'd2) && (gen_reg != GEN_RSV);

    // Next-state and control: flush, accept/reject, unload sequencing.
    always_comb begin
        flush       = !enable || (gen_speed != gen_reg);
        n_last      = (gen_reg == GEN_3) ? 4'd7 : ((gen_reg == GEN_4) ? 4'd15 : 4'd0);
        emit        = !flush && ((state_reg == UNLOAD) || (count_reg != 2'd0));
        last        = (idx_reg == n_last);
        pop         = emit && last;
        accept      = sym_valid && sym_ready && !flush;
        reject      = !((g_lane[0].is_data || g_lane[0].is_os) &&
                        (g_lane[1].is_data || g_lane[1].is_os)) ||
                      (g_lane[0].is_os != g_lane[1].is_os);
        wr_en       = accept && !reject;

        count_next  = count_reg;
        idx_next    = idx_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        state_next  = state_reg;

        if (flush) begin
            count_next  = 2'd0;
            idx_next    = 4'd0;
            wr_ptr_next = 1'b0;
            rd_ptr_next = 1'b0;
            state_next  = IDLE;
        end else begin
            count_next = count_reg + {1'b0, wr_en} - {1'b0, pop};
            if (emit) begin
                idx_next = last ? 4'd0 : idx_reg + 4'd1;
            end
            if (pop) begin
                rd_ptr_next = !rd_ptr_reg;
            end
            if (wr_en) begin
                wr_ptr_next = !wr_ptr_reg;
            end
            state_next = (count_next != 2'd0) ? UNLOAD : IDLE;
        end
    end

    // State, FIFO bookkeeping, status outputs and error counter.
    always_ff @(posedge dec_clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            en_reg       <= 1'b0;
            gen_reg      <= GEN_RAW;
            count_reg    <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            idx_reg      <= 4'd0;
            rx_valid_reg <= 1'b0;
            rx_sos_reg   <= 1'b0;
            rx_os_reg    <= 1'b0;
            rej_pend_reg <= 1'b0;
            sync_err_reg <= 1'b0;
            err_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            en_reg       <= enable;
            gen_reg      <= gen_speed;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            idx_reg      <= idx_next;
            rx_valid_reg <= emit;
            rx_sos_reg   <= emit && (idx_reg == 4'd0);
            rx_os_reg    <= emit && mem_type[rd_ptr_reg];
            // The reject is reported one cycle after the accept, in step with
            // where byte 0 of an accepted symbol would have appeared.
            rej_pend_reg <= accept && reject;
            sync_err_reg <= !flush && rej_pend_reg;
            if (!flush && rej_pend_reg && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
            end
        end
    end

    assign lane_0_rx = g_lane[0].byte_reg;
    assign lane_1_rx = g_lane[1].byte_reg;
    assign rx_valid  = rx_valid_reg;
    assign rx_sos    = rx_sos_reg;
    assign rx_os     = rx_os_reg;
    assign sync_err  = sync_err_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_decoding_block.sv
// Self-checking bench for decoding_block: directed scenarios plus a random
// run, all compared against a symbol-level reference model.
module tb_decoding_block;

    logic         dec_clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic [1:0]   gen_speed = 2'd0;
    logic [131:0] lane_0_rx_enc = '0;
    logic [131:0] lane_1_rx_enc = '0;
    logic         sym_valid = 1'b0;
    logic         sym_ready;
    logic [7:0]   lane_0_rx, lane_1_rx;
    logic         rx_valid, rx_sos, rx_os, sync_err;
    logic [7:0]   err_cnt;

    logic         sym_ready2;
    logic [7:0]   lane_0_rx2, lane_1_rx2;
    logic         rx_valid2, rx_sos2, rx_os2, sync_err2;
    logic [1:0]   err_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 dec_clk = ~dec_clk;

    decoding_block #(.ERR_CNT_W(8)) u_dut (
        .dec_clk(dec_clk), .rst(rst), .enable(enable), .gen_speed(gen_speed),
        .lane_0_rx_enc(lane_0_rx_enc), .lane_1_rx_enc(lane_1_rx_enc),
        .sym_valid(sym_valid), .sym_ready(sym_ready),
        .lane_0_rx(lane_0_rx), .lane_1_rx(lane_1_rx), .rx_valid(rx_valid),
        .rx_sos(rx_sos), .rx_os(rx_os), .sync_err(sync_err), .err_cnt(err_cnt)
    );

    decoding_block #(.ERR_CNT_W(2)) u_dut2 (
        .dec_clk(dec_clk), .rst(rst), .enable(enable), .gen_speed(gen_speed),
        .lane_0_rx_enc(lane_0_rx_enc), .lane_1_rx_enc(lane_1_rx_enc),
        .sym_valid(sym_valid), .sym_ready(sym_ready2),
        .lane_0_rx(lane_0_rx2), .lane_1_rx(lane_1_rx2), .rx_valid(rx_valid2),
        .rx_sos(rx_sos2), .rx_os(rx_os2), .sync_err(sync_err2), .err_cnt(err_cnt2)
    );

    logic [28:0] dut_obs;
    assign dut_obs = {lane_0_rx, lane_1_rx, rx_valid, rx_sos, rx_os, sync_err, sym_ready, err_cnt};

    // ---------------- reference model ----------------
    typedef struct {
        logic [127:0] p0;
        logic [127:0] p1;
        bit           os;
    } sym_t;

    sym_t       symq[$];
    bit         m_en = 0;
    logic [1:0] m_gen = 2'd0;
    int         m_idx = 0;
    logic [7:0] m_l0 = 0, m_l1 = 0;
    bit         m_v = 0, m_sos = 0, m_os = 0, m_serr = 0, m_pend = 0, m_acc = 0;
    int         m_cnt = 0;

    function automatic int nbytes(logic [1:0] g);
        return (g == 2'd2) ? 8 : ((g == 2'd1) ? 16 : 1);
    endfunction

    // -1 illegal, 0 data, 1 ordered set
    function automatic int classify(logic [1:0] g, logic [131:0] e);
        if (g == 2'd2) return (e[1:0] == 2'b01) ? 0 : ((e[1:0] == 2'b10) ? 1 : -1);
        if (g == 2'd1) return (e[3:0] == 4'b0101) ? 0 : ((e[3:0] == 4'b1010) ? 1 : -1);
        return 0;
    endfunction

    function automatic logic [127:0] payload(logic [1:0] g, logic [131:0] e);
        logic [127:0] p;
        p = '0;
        if (g == 2'd2) p[63:0] = e[65:2];
        else if (g == 2'd1) p = e[131:4];
        else p[7:0] = e[7:0];
        return p;
    endfunction

    function automatic logic [131:0] rand132();
        logic [131:0] e;
        for (int i = 0; i < 4; i++) e[32*i +: 32] = $urandom;
        e[131:128] = 4'($urandom_range(0, 15));
        return e;
    endfunction

    // Build an encoded symbol for mode g with the given payload and header.
    function automatic logic [131:0] mk(logic [1:0] g, logic [127:0] p, logic [3:0] h);
        logic [131:0] e;
        e = rand132();
        if (g == 2'd2) e[65:0] = {p[63:0], h[1:0]};
        else if (g == 2'd1) e = {p, h};
        else e[7:0] = p[7:0];
        return e;
    endfunction

    function automatic logic [127:0] rand128();
        logic [127:0] p;
        for (int i = 0; i < 4; i++) p[32*i +: 32] = $urandom;
        return p;
    endfunction

    function automatic logic [28:0] model_obs();
        bit   rdy;
        logic [7:0] c;
        rdy = m_en && (m_gen != 2'd3) && (symq.size() < 2);
        c = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
        return {m_l0, m_l1, m_v, m_sos, m_os, m_serr, rdy, c};
    endfunction

    // Advance the model by one clock using current inputs, then clock the DUT.
    task automatic tick();
        bit           flush, rdy;
        int           t0, t1;
        logic [127:0] tp;
        sym_t         s;
        flush = !enable || (gen_speed != m_gen);
        rdy   = m_en && (m_gen != 2'd3) && (symq.size() < 2);
        m_acc = 0;
        if (flush) begin
            symq.delete();
            m_idx = 0; m_v = 0; m_sos = 0; m_os = 0; m_l0 = 0; m_l1 = 0;
            m_serr = 0; m_pend = 0;
        end else begin
            m_serr = m_pend;
            if (m_pend) m_cnt++;
            if (symq.size() > 0) begin
                tp = symq[0].p0; m_l0 = tp[8*m_idx +: 8];
                tp = symq[0].p1; m_l1 = tp[8*m_idx +: 8];
                m_v = 1; m_sos = (m_idx == 0); m_os = symq[0].os;
                m_idx++;
                if (m_idx == nbytes(m_gen)) begin
                    void'(symq.pop_front());
                    m_idx = 0;
                end
            end else begin
                m_v = 0; m_sos = 0; m_os = 0; m_l0 = 0; m_l1 = 0;
            end
            m_pend = 0;
            if (sym_valid && rdy) begin
                m_acc = 1;
                t0 = classify(m_gen, lane_0_rx_enc);
                t1 = classify(m_gen, lane_1_rx_enc);
                if (t0 < 0 || t1 < 0 || t0 != t1) begin
                    m_pend = 1;
                end else begin
                    s.p0 = payload(m_gen, lane_0_rx_enc);
                    s.p1 = payload(m_gen, lane_1_rx_enc);
                    s.os = (t0 == 1);
                    symq.push_back(s);
                end
            end
        end
        m_gen = gen_speed;
        m_en  = enable;
        @(posedge dec_clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #12;
        n_checks++;
        if (dut_obs !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", dut_obs);
        end
        @(negedge dec_clk);
        rst = 1'b1;
        enable = 1'b1;
        gen_speed = 2'd2;
        tick();
        n_checks++;
        if (sym_ready !== 1'b1 || dut_obs !== model_obs()) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %h want %h", dut_obs, model_obs());
        end
        $display("test_reset done");
    endtask

    task automatic test_gen3_data();
        lane_0_rx_enc = mk(2'd2, 128'h0807060504030201, 4'b0001);
        lane_1_rx_enc = mk(2'd2, 128'hF8F7F6F5F4F3F2F1, 4'b0001);
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            n_checks++;
            if (dut_obs !== model_obs()) begin
                n_fail++;
                $display("FAIL gen3_model k=%0d: got %h want %h", k, dut_obs, model_obs());
            end
            n_checks++;
            if (k < 8 && {lane_0_rx, lane_1_rx, rx_valid, rx_sos, rx_os, sync_err} !==
                    {8'(k + 1), 8'(8'hF1 + k), 1'b1, (k == 0), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL gen3_byte k=%0d: got %h/%h v%b s%b want %h/%h",
                         k, lane_0_rx, lane_1_rx, rx_valid, rx_sos, 8'(k + 1), 8'(8'hF1 + k));
            end else if (k == 8 && rx_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL gen3_idle: got rx_valid %b want 0", rx_valid);
            end
        end
        $display("test_gen3_data done");
    endtask

    task automatic test_gen4_back_to_back();
        logic [127:0] pa, pb;
        gen_speed = 2'd1;
        tick();
        for (int k = 0; k < 16; k++) pa[8*k +: 8] = 8'(k);
        pb = rand128();
        lane_0_rx_enc = mk(2'd1, pa, 4'b1010);
        lane_1_rx_enc = mk(2'd1, rand128(), 4'b1010);
        sym_valid = 1'b1;
        tick();
        lane_0_rx_enc = mk(2'd1, pb, 4'b0101);
        lane_1_rx_enc = mk(2'd1, rand128(), 4'b0101);
        for (int t = 1; t <= 34; t++) begin
            tick();
            if (t == 1) sym_valid = 1'b0;
            n_checks++;
            if (dut_obs !== model_obs()) begin
                n_fail++;
                $display("FAIL gen4_model t=%0d: got %h want %h", t, dut_obs, model_obs());
            end
            if (t <= 16) begin
                n_checks++;
                if ({lane_0_rx, rx_valid, rx_os, rx_sos} !== {8'(t - 1), 1'b1, 1'b1, (t == 1)}) begin
                    n_fail++;
                    $display("FAIL gen4_os_byte t=%0d: got %h v%b o%b s%b want %h",
                             t, lane_0_rx, rx_valid, rx_os, rx_sos, 8'(t - 1));
                end
            end else if (t == 17) begin
                n_checks++;
                if ({rx_valid, rx_sos, rx_os, lane_0_rx} !== {1'b1, 1'b1, 1'b0, pb[7:0]}) begin
                    n_fail++;
                    $display("FAIL gen4_no_gap: got v%b s%b o%b %h want v1 s1 o0 %h",
                             rx_valid, rx_sos, rx_os, lane_0_rx, pb[7:0]);
                end
            end else if (t == 33) begin
                n_checks++;
                if (rx_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gen4_idle: got rx_valid %b want 0", rx_valid);
                end
            end
        end
        $display("test_gen4_back_to_back done");
    endtask

    task automatic test_header_err();
        logic [3:0] h0 [2];
        logic [3:0] h1 [2];
        h0[0] = 4'b0011; h1[0] = 4'b0001;
        h0[1] = 4'b0001; h1[1] = 4'b0010;
        gen_speed = 2'd2;
        tick();
        for (int i = 0; i < 2; i++) begin
            lane_0_rx_enc = mk(2'd2, rand128(), h0[i]);
            lane_1_rx_enc = mk(2'd2, rand128(), h1[i]);
            sym_valid = 1'b1;
            tick();
            sym_valid = 1'b0;
            tick();
            n_checks++;
            if ({sync_err, err_cnt, rx_valid} !== {1'b1, 8'(i + 1), 1'b0} || dut_obs !== model_obs()) begin
                n_fail++;
                $display("FAIL hdr_err%0d: got serr %b cnt %0d v %b want 1 %0d 0",
                         i, sync_err, err_cnt, rx_valid, i + 1);
            end
            tick();
            n_checks++;
            if ({sync_err, rx_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL hdr_err_pulse%0d: got serr %b v %b want 0 0", i, sync_err, rx_valid);
            end
        end
        $display("test_header_err done");
    endtask

    task automatic test_flow_control();
        logic [131:0] s0 [3];
        logic [131:0] s1 [3];
        int idx;
        for (int i = 0; i < 3; i++) begin
            s0[i] = mk(2'd2, rand128(), 4'b0001);
            s1[i] = mk(2'd2, rand128(), 4'b0001);
        end
        idx = 0;
        lane_0_rx_enc = s0[0];
        lane_1_rx_enc = s1[0];
        sym_valid = 1'b1;
        for (int t = 1; t <= 27; t++) begin
            tick();
            if (m_acc) idx++;
            if (idx < 3) begin
                lane_0_rx_enc = s0[idx];
                lane_1_rx_enc = s1[idx];
            end else begin
                sym_valid = 1'b0;
            end
            n_checks++;
            if (dut_obs !== model_obs()) begin
                n_fail++;
                $display("FAIL flow_model t=%0d: got %h want %h", t, dut_obs, model_obs());
            end
            n_checks++;
            if (t >= 2 && t <= 8 && sym_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL flow_ready_low t=%0d: got %b want 0", t, sym_ready);
            end else if (t == 9 && sym_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL flow_ready_high t=%0d: got %b want 1", t, sym_ready);
            end else if (t >= 2 && t <= 25 && rx_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL flow_gap t=%0d: got rx_valid %b want 1", t, rx_valid);
            end else if (t == 26 && rx_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flow_end t=%0d: got rx_valid %b want 0", t, rx_valid);
            end
        end
        $display("test_flow_control done");
    endtask

    task automatic test_flush();
        logic [127:0] p2;
        gen_speed = 2'd1;
        tick();
        lane_0_rx_enc = mk(2'd1, rand128(), 4'b0101);
        lane_1_rx_enc = mk(2'd1, rand128(), 4'b0101);
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (dut_obs !== model_obs()) begin
                n_fail++;
                $display("FAIL flush_pre k=%0d: got %h want %h", k, dut_obs, model_obs());
            end
        end
        enable = 1'b0;
        tick();
        n_checks++;
        if ({rx_valid, sym_ready, rx_sos, err_cnt} !== {1'b0, 1'b0, 1'b0, 8'd2} || dut_obs !== model_obs()) begin
            n_fail++;
            $display("FAIL flush_state: got v%b r%b cnt %0d want v0 r0 cnt 2", rx_valid, sym_ready, err_cnt);
        end
        enable = 1'b1;
        tick();
        n_checks++;
        if (sym_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_reenable: got ready %b want 1", sym_ready);
        end
        p2 = rand128();
        lane_0_rx_enc = mk(2'd1, p2, 4'b0101);
        lane_1_rx_enc = mk(2'd1, rand128(), 4'b0101);
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        for (int k = 0; k < 17; k++) begin
            tick();
            n_checks++;
            if (dut_obs !== model_obs()) begin
                n_fail++;
                $display("FAIL flush_post k=%0d: got %h want %h", k, dut_obs, model_obs());
            end
            if (k == 0) begin
                n_checks++;
                if ({lane_0_rx, rx_sos, rx_valid} !== {p2[7:0], 1'b1, 1'b1}) begin
                    n_fail++;
                    $display("FAIL flush_restart: got %h s%b v%b want %h s1 v1",
                             lane_0_rx, rx_sos, rx_valid, p2[7:0]);
                end
            end
        end
        $display("test_flush done");
    endtask

    task automatic test_raw();
        gen_speed = 2'd0;
        tick();
        lane_0_rx_enc = rand132();
        lane_1_rx_enc = rand132();
        lane_0_rx_enc[7:0] = 8'hA5;
        lane_1_rx_enc[7:0] = 8'h5A;
        sym_valid = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t == 4) sym_valid = 1'b0;
            n_checks++;
            if (dut_obs !== model_obs()) begin
                n_fail++;
                $display("FAIL raw_model t=%0d: got %h want %h", t, dut_obs, model_obs());
            end
            n_checks++;
            if (t >= 2 && t <= 5 && {lane_0_rx, lane_1_rx, rx_valid, rx_sos, rx_os, sync_err} !==
                    {8'hA5, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL raw_byte t=%0d: got %h/%h v%b s%b want a5/5a v1 s1",
                         t, lane_0_rx, lane_1_rx, rx_valid, rx_sos);
            end else if (t == 6 && rx_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL raw_end: got rx_valid %b want 0", rx_valid);
            end
        end
        $display("test_raw done");
    endtask

    task automatic test_saturation();
        logic [1:0] exp2;
        gen_speed = 2'd2;
        tick();
        for (int i = 0; i < 6; i++) begin
            lane_0_rx_enc = mk(2'd2, rand128(), 4'b0001);
            lane_1_rx_enc = mk(2'd2, rand128(), 4'b0010);
            sym_valid = 1'b1;
            tick();
            sym_valid = 1'b0;
            tick();
            exp2 = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
            n_checks++;
            if (err_cnt2 !== exp2 || dut_obs !== model_obs()) begin
                n_fail++;
                $display("FAIL sat_step%0d: got cnt2 %0d cnt %0d want %0d %0d",
                         i, err_cnt2, err_cnt, exp2, m_cnt);
            end
        end
        tick();
        n_checks++;
        if (err_cnt2 !== 2'd3 || err_cnt !== 8'd8) begin
            n_fail++;
            $display("FAIL sat_final: got cnt2 %0d cnt %0d want 3 8", err_cnt2, err_cnt);
        end
        $display("test_saturation done");
    endtask

    task automatic test_random();
        bit         os;
        logic [3:0] h0, h1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 59) == 0) gen_speed = 2'($urandom_range(0, 3));
            enable    = ($urandom_range(0, 49) != 0);
            sym_valid = ($urandom_range(0, 2) != 0);
            os = 1'($urandom_range(0, 1));
            h0 = (gen_speed == 2'd2) ? (os ? 4'b0010 : 4'b0001) : (os ? 4'b1010 : 4'b0101);
            h1 = h0;
            if ($urandom_range(0, 9) == 0) h0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) h1 = 4'($urandom_range(0, 15));
            lane_0_rx_enc = mk(gen_speed, rand128(), h0);
            lane_1_rx_enc = mk(gen_speed, rand128(), h1);
            tick();
            n_checks++;
            if (dut_obs !== model_obs()) begin
                n_fail++;
                $display("FAIL random cyc=%0d: got %h want %h", cyc, dut_obs, model_obs());
            end
        end
        sym_valid = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_gen3_data();
        test_gen4_back_to_back();
        test_header_err();
        test_flow_control();
        test_flush();
        test_raw();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
